// File: rtl/muxn_pipe_pkg.sv
// Shared types for the N-way registered select stage: arbitration mode and default word type.
package muxn_pipe_pkg;

  typedef enum logic {
    MUXN_MODE_SEL = 1'b0,
    MUXN_MODE_RR  = 1'b1
  } muxn_mode_e;

  localparam int unsigned MUXN_WORD_W = 64;

  typedef logic [MUXN_WORD_W-1:0] muxn_word_t;

endpackage

// File: rtl/muxn_pipe_rr_pick.sv
// Rotate-priority picker: first requester at or after ptr, wrapping, via a doubled request vector.
module muxn_pipe_rr_pick #(
  parameter  int unsigned N    = 4,
  localparam int unsigned SELW = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [SELW-1:0] ptr,
  output logic [N-1:0]    gnt,
  output logic [SELW-1:0] gnt_idx,
  output logic            any
);

  logic [2*N-1:0] dbl;

  // Masking the low copy below ptr lets the upper copy supply the wrap without a modulo.
  always_comb begin
    dbl     = {req, req};
    gnt_idx = '0;
    any     = 1'b0;
    for (int i = 0; i < int'(N); i++) begin
      if (i < int'(ptr)) dbl[i] = 1'b0;
    end
    for (int i = 2*int'(N) - 1; i >= 0; i--) begin
      if (dbl[i]) begin
        any     = 1'b1;
        gnt_idx = (i >= int'(N)) ? SELW'(i - int'(N)) : SELW'(i);
      end
    end
    gnt = any ? (N'(1) << gnt_idx) : '0;
  end

endmodule

// File: rtl/muxn_pipe.sv
// N-way WIDTH-bit select stage with a one-entry registered output and valid/ready on every channel.
module muxn_pipe
  import muxn_pipe_pkg::*;
#(
  parameter  int unsigned N     = 4,
  parameter  int unsigned WIDTH = MUXN_WORD_W,
  parameter  muxn_mode_e  MODE  = MUXN_MODE_SEL,
  localparam int unsigned SELW  = $clog2(N)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [N-1:0]       in_valid,
  input  logic [N*WIDTH-1:0] in_data,
  output logic [N-1:0]       in_ready,
  input  logic [SELW-1:0]    sel,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_data,
  output logic [SELW-1:0]    out_src,
  input  logic               out_ready
);

  logic               out_valid_q, out_valid_d;
  logic [WIDTH-1:0]   out_data_q, out_data_d;
  logic [SELW-1:0]    out_src_q, out_src_d;
  logic [SELW-1:0]    ptr_q, ptr_d;

  logic               load_c;
  logic [N-1:0]       grant_c;
  logic [SELW-1:0]    gidx_c;
  logic               any_c;
  logic [WIDTH-1:0]   gdata_c;

  logic [N-1:0]       rr_gnt;
  logic [SELW-1:0]    rr_idx;
  logic               rr_any;

  generate
    if (MODE == MUXN_MODE_RR) begin : g_rr
      muxn_pipe_rr_pick #(.N(N)) u_rr_pick (
        .req     (in_valid),
        .ptr     (ptr_q),
        .gnt     (rr_gnt),
        .gnt_idx (rr_idx),
        .any     (rr_any)
      );
    end else begin : g_no_rr
      assign rr_gnt = '0;
      assign rr_idx = '0;
      assign rr_any = 1'b0;
    end
  endgenerate

  assign load_c = !out_valid_q || out_ready;

  // Grant selection; an out-of-range sel grants nothing.
  always_comb begin
    grant_c = '0;
    gidx_c  = '0;
    if (MODE == MUXN_MODE_RR) begin
      grant_c = rr_gnt;
      gidx_c  = rr_idx;
    end else if (int'(sel) < int'(N)) begin
      grant_c[sel] = in_valid[sel];
      gidx_c       = sel;
    end
    any_c = |grant_c;
  end

  always_comb begin
    gdata_c = '0;
    for (int i = 0; i < int'(N); i++) begin
      if (SELW'(i) == gidx_c) gdata_c = in_data[i*WIDTH +: WIDTH];
    end
  end

  assign in_ready = reset_n ? (load_c ? grant_c : '0) : '0;

  // Output register and RR pointer next state; everything holds under backpressure.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
    ptr_d       = ptr_q;
    if (load_c) begin
      if (any_c) begin
        out_valid_d = 1'b1;
        out_data_d  = gdata_c;
        out_src_d   = gidx_c;
        ptr_d       = (gidx_c == SELW'(N - 1)) ? '0 : SELW'(gidx_c + SELW'(1));
      end else begin
        out_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= '0;
      ptr_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_src   = out_src_q;

endmodule

// File: doc/muxn_pipe.md
Name: muxn_pipe

Overview:
- Parametrised N-way, WIDTH-bit select stage with a registered output and valid/ready handshakes on every input channel and on the output.
- Generalises the combinational 4-way 64-bit mux to an arbitrary channel count and width.
- Adds a round-robin arbitration mode alongside explicit select.
- Used wherever the core must merge multiple producers into one consumer across a pipeline boundary: writeback source merge, multi-source memory request merge, forwarding-path retiming.

Parameters:
- N, 4: number of input channels, N >= 2.
- WIDTH, 64: data width in bits.
- MODE, MUXN_MODE_SEL: MUXN_MODE_SEL = explicit select via sel; MUXN_MODE_RR = round-robin among valid inputs, sel ignored.
- SELW, $clog2(N): width of sel and out_src (derived; not overridden).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- in_valid  input  N  per-channel valid.
- in_data  input  N*WIDTH  packed channel data; channel i occupies bits [i*WIDTH +: WIDTH].
- in_ready  output  N  per-channel ready (combinational).
- sel  input  SELW  channel index in MUXN_MODE_SEL; ignored in MUXN_MODE_RR.
- out_valid  output  1  registered output valid.
- out_data  output  WIDTH  registered output data.
- out_src  output  SELW  registered index of the channel that supplied out_data.
- out_ready  input  1  consumer ready.

Behaviour:
- Reset (reset_n low, asynchronous):
  - out_valid=0, out_data=0, out_src=0, RR pointer ptr=0.
  - A buffered beat is discarded.
  - in_ready is 0 for all channels while reset_n is low.
- Output stage: one-entry register. load = !out_valid || out_ready.
- Grant, combinational, at most one-hot:
  - MUXN_MODE_SEL: grant[sel] = in_valid[sel] when sel < N. If sel >= N, no grant and all in_ready=0.
  - MUXN_MODE_RR: grant goes to the first i with in_valid[i]=1, scanning ptr, ptr+1, ..., ptr+N-1 mod N.
- in_ready[i] = load && grant[i]. in_ready never depends on in_valid[i] of the same channel except through grant. in_ready[i]=0 for all non-granted channels.
- Transfer on rising edge:
  - load && |grant: out_data <= in_data[g], out_src <= g, out_valid <= 1.
  - load && !|grant: out_valid <= 0; out_data and out_src hold.
  - !load: all outputs hold (backpressure). The producer must hold its valid and data.
- RR pointer: on a transfer from channel g, ptr <= (g+1) mod N, with wrap for non-power-of-2 N. It holds otherwise, including under backpressure.
- Latency: 1 cycle from input handshake to out_valid. Throughput: 1 beat/cycle when out_ready is held high.
- Simultaneous out_ready and new input in the same cycle: the old beat is consumed and the new beat is loaded. No bubble.
- sel may change every cycle. It is sampled only in the cycle of the transfer; the registered beat is unaffected by later sel changes.
- No combinational path from in_* to out_*. The only combinational path from out_ready is to in_ready.

Decomposition:
- Package common:
  - typedef enum for mode: MUXN_MODE_SEL=0, MUXN_MODE_RR=1.
  - Shared word typedef for the default WIDTH=64.
- Sub-module rr_pick: combinational rotate-priority picker.
  - Ports: req[N], ptr[SELW] -> gnt[N] one-hot, gnt_idx[SELW], any.
  - Instantiated only when MODE==MUXN_MODE_RR (generate).
  - Handles non-power-of-2 N by double-width masking, not by rotate-modulo.

Test Plan:
- Reset mid-beat:
  - Load beat 0xAA from ch2, hold out_ready=0, pulse reset_n low between clock edges.
  - Required: out_valid=0, out_data=0 immediately (asynchronous); ptr=0 after release.
- SEL basic:
  - N=4, WIDTH=64, sel=2, in_valid=4'b1111, in_data[2]=0xDEAD_BEEF, out_ready=1.
  - Required: in_ready=4'b0100; next cycle out_valid=1, out_data=0xDEAD_BEEF, out_src=2.
- SEL out of range:
  - N=3, SELW=2, sel=3, all valid.
  - Required: in_ready=0 for all channels, out_valid drops to 0 next cycle.
- Backpressure:
  - Beat from ch1 (0x11) loaded, out_ready=0 for 3 cycles while ch0 is valid (0x22).
  - Required: out_data stays 0x11 and in_ready=0 throughout. When out_ready=1: 0x11 is consumed and 0x22 is loaded the same edge with no bubble.
- RR fairness:
  - MODE=RR, N=4, all channels valid continuously, out_ready=1.
  - Required: out_src sequence 0,1,2,3,0,1 with no gaps.
  - With only ch1 and ch3 valid: sequence 1,3,1,3.
- RR non-power-of-2 wrap:
  - N=3, all valid.
  - Required: out_src 0,1,2,0; ptr never equals 3.
  - Under backpressure the pointer holds and does not skip a channel.
